// File: rtl/aes128_encrypt_iter_pkg.sv
// Shared AES-128 constants, types and byte-level helpers for the iterative encryption core.
// Byte 0 of a block sits in bits [127:120]; the state is stored column-major.
package aes128_encrypt_iter_pkg;

  localparam int unsigned NR       = 10;
  localparam int unsigned RK_BUS_W = 128 * (NR + 1);

  typedef logic [127:0] aes_state_t;

  typedef enum logic [1:0] {
    StIdle,
    StRound,
    StFinal,
    StDone
  } aes_fsm_e;

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry b starts at bit 2047 - 8*b, which is {~b, 3'b111}.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gmul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  // 11:1 round-key mux; out-of-range indices yield zero rather than an illegal slice.
  function automatic aes_state_t rk_slice(input logic [RK_BUS_W-1:0] bus, input logic [3:0] i);
    aes_state_t rk;
    rk = '0;
    for (int k = 0; k <= int'(NR); k++) begin
      if (i == 4'(k)) begin
        rk = bus[RK_BUS_W-1-128*k -: 128];
      end
    end
    return rk;
  endfunction

endpackage

// File: rtl/aes128_encrypt_iter_if.sv
// Block-in / block-out handshake bundle between KeyExpansion, the AES core and its sink.
interface aes128_encrypt_iter_if
  import aes128_encrypt_iter_pkg::*;
;

  logic                in_valid;
  logic                in_ready;
  aes_state_t          plaintext;
  logic [RK_BUS_W-1:0] round_keys;
  logic                out_valid;
  logic                out_ready;
  aes_state_t          ciphertext;
  logic                busy;

  modport master (
    output in_valid,
    output plaintext,
    output round_keys,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  ciphertext,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  plaintext,
    input  round_keys,
    input  out_ready,
    output in_ready,
    output out_valid,
    output ciphertext,
    output busy
  );

endinterface

// File: rtl/aes128_encrypt_iter_round.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes128_encrypt_iter_round
  import aes128_encrypt_iter_pkg::*;
(
  input  aes_state_t state_in,
  input  aes_state_t rk,
  input  logic       final_rnd,
  output aes_state_t state_out
);

  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];
  aes_state_t mixed;

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      sb[i] = sbox(state_in[127-8*i -: 8]);
    end
  end

  // Row r of column c takes the byte from column (c + r) mod 4.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[4*c+r] = sb[4*((c+r)%4)+r];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      mc[4*c+0] = gmul2(sr[4*c]) ^ gmul3(sr[4*c+1]) ^ sr[4*c+2]        ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c]        ^ gmul2(sr[4*c+1]) ^ gmul3(sr[4*c+2]) ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c]        ^ sr[4*c+1]        ^ gmul2(sr[4*c+2]) ^ gmul3(sr[4*c+3]);
      mc[4*c+3] = gmul3(sr[4*c]) ^ sr[4*c+1]        ^ sr[4*c+2]        ^ gmul2(sr[4*c+3]);
    end
  end

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      mixed[127-8*i -: 8] = final_rnd ? sr[i] : mc[i];
    end
  end

  assign state_out = mixed ^ rk;

endmodule

// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryption core: one round per clock, 12-cycle minimum block period.
// Round keys are read straight off the KeyExpansion bus, so upstream holds them while busy.
module aes128_encrypt_iter
  import aes128_encrypt_iter_pkg::*;
#(
  parameter int unsigned NR = aes128_encrypt_iter_pkg::NR
) (
  input logic                  clk,
  input logic                  rst_n,
  aes128_encrypt_iter_if.slave bus
);

  if (NR != 10) begin : g_nr_check
    $error("aes128_encrypt_iter: only NR = 10 (AES-128) is supported");
  end

  aes_fsm_e   fsm_q, fsm_d;
  aes_state_t state_q, state_d;
  logic [3:0] round_ctr_q, round_ctr_d;
  logic       rdy_q;
  aes_state_t rk_cur;
  aes_state_t round_out;
  logic       accept;

  // round_ctr is 0 in idle, so the same mux supplies rk[0] for the initial whitening.
  assign rk_cur = rk_slice(bus.round_keys, round_ctr_q);
  assign accept = bus.in_valid && rdy_q;

  aes128_encrypt_iter_round u_round (
    .state_in  (state_q),
    .rk        (rk_cur),
    .final_rnd (fsm_q == StFinal),
    .state_out (round_out)
  );

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    round_ctr_d = round_ctr_q;
    unique case (fsm_q)
      StIdle: begin
        if (accept) begin
          state_d     = bus.plaintext ^ rk_cur;
          round_ctr_d = 4'd1;
          fsm_d       = StRound;
        end
      end
      StRound: begin
        state_d     = round_out;
        round_ctr_d = round_ctr_q + 4'd1;
        if (round_ctr_q == 4'(NR - 1)) begin
          fsm_d = StFinal;
        end
      end
      StFinal: begin
        state_d = round_out;
        fsm_d   = StDone;
      end
      StDone: begin
        if (bus.out_ready) begin
          round_ctr_d = '0;
          fsm_d       = StIdle;
        end
      end
      default: begin
        round_ctr_d = '0;
        fsm_d       = StIdle;
      end
    endcase
  end

  // in_ready is registered so it stays low while rst_n is asserted and rises on the first edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= StIdle;
      state_q     <= '0;
      round_ctr_q <= '0;
      rdy_q       <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      round_ctr_q <= round_ctr_d;
      rdy_q       <= (fsm_d == StIdle);
    end
  end

  assign bus.in_ready   = rdy_q;
  assign bus.out_valid  = (fsm_q == StDone);
  assign bus.busy       = (fsm_q != StIdle);
  assign bus.ciphertext = (fsm_q == StDone) ? state_q : '0;

  ctr_bound_a : assert property (@(posedge clk) disable iff (!rst_n)
    round_ctr_q <= 4'(NR));

  ready_idle_a : assert property (@(posedge clk) disable iff (!rst_n)
    bus.in_ready |-> (fsm_q == StIdle));

  hold_a : assert property (@(posedge clk) disable iff (!rst_n)
    (bus.out_valid && !bus.out_ready) |=> (bus.out_valid && $stable(bus.ciphertext)));

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// Scoreboard bench for aes128_encrypt_iter using FIPS-197 vectors; the bench expands keys itself.
module tb_aes128_encrypt_iter;

  localparam logic [2047:0] TB_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [127:0]  exp_q [$];
  logic [1407:0] rk_b, rk_c, rk_z;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes128_encrypt_iter_if aes_bus ();

  aes128_encrypt_iter #(.NR(10)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (aes_bus)
  );

  function automatic logic [7:0] tb_sbox(input logic [7:0] b);
    return TB_SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [1407:0] expand_key(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [1407:0] rks;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {tb_sbox(t[23:16]), tb_sbox(t[15:8]), tb_sbox(t[7:0]), tb_sbox(t[31:24])}
            ^ {rcon, 24'h0};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) rks[1407-32*i -: 32] = w[i];
    return rks;
  endfunction

  task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: one pop per completed output handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && aes_bus.out_valid && aes_bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_output: got %h, expected no output", aes_bus.ciphertext);
        end else begin
          check128("ciphertext", aes_bus.ciphertext, exp_q.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [127:0] pt, input logic [1407:0] rks, input logic [127:0] exp,
                      output int acc);
    int n = 0;
    while (!aes_bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_bit("in_ready_before_send", aes_bus.in_ready, 1'b1);
    aes_bus.plaintext  = pt;
    aes_bus.round_keys = rks;
    aes_bus.in_valid   = 1'b1;
    @(posedge clk); #1;
    aes_bus.in_valid = 1'b0;
    exp_q.push_back(exp);
    acc = cyc;
    check_bit("busy_after_accept", aes_bus.busy, 1'b1);
  endtask

  task automatic wait_valid(output int edges);
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
    end while (!aes_bus.out_valid && edges < 50);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(aes_bus.in_ready && exp_q.size() == 0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_int("pending_results", exp_q.size(), 0);
    check_bit("idle_in_ready", aes_bus.in_ready, 1'b1);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check_bit("rst_out_valid", aes_bus.out_valid, 1'b0);
    check_bit("rst_busy", aes_bus.busy, 1'b0);
    check128("rst_ciphertext", aes_bus.ciphertext, 128'h0);
    check_bit("rst_in_ready", aes_bus.in_ready, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_bit("in_ready_after_release", aes_bus.in_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int edges;
    int accs [5];
    logic [127:0]  b2b_pt [5];
    logic [127:0]  b2b_ct [5];
    logic [1407:0] b2b_rk [5];

    aes_bus.in_valid   = 1'b0;
    aes_bus.out_ready  = 1'b0;
    aes_bus.plaintext  = '0;
    aes_bus.round_keys = '0;
    rk_b = expand_key(KEY_B);
    rk_c = expand_key(KEY_C);
    rk_z = expand_key(128'h0);

    // Reset state and release.
    apply_reset();

    // FIPS-197 App.B with exact latency.
    aes_bus.out_ready = 1'b1;
    send(PT_B, rk_b, CT_B, acc);
    wait_valid(edges);
    check_int("latency_app_b", edges, 10);
    wait_idle();

    // FIPS-197 App.C.1.
    send(PT_C, rk_c, CT_C, acc);
    wait_valid(edges);
    check_int("latency_app_c1", edges, 10);
    wait_idle();

    // Zero block followed by four back-to-back blocks.
    b2b_pt = '{128'h0, PT_B, PT_C, 128'h0, PT_B};
    b2b_ct = '{CT_Z, CT_B, CT_C, CT_Z, CT_B};
    b2b_rk = '{rk_z, rk_b, rk_c, rk_z, rk_b};
    for (int i = 0; i < 5; i++) begin
      send(b2b_pt[i], b2b_rk[i], b2b_ct[i], accs[i]);
      if (i > 0) check_int("b2b_spacing", accs[i] - accs[i-1], 12);
    end
    wait_idle();

    // Backpressure: sink stalls five cycles after out_valid.
    aes_bus.out_ready = 1'b0;
    send(PT_B, rk_b, CT_B, acc);
    wait_valid(edges);
    check_int("latency_backpressure", edges, 10);
    for (int i = 0; i < 5; i++) begin
      check_bit("stall_out_valid", aes_bus.out_valid, 1'b1);
      check128("stall_ciphertext", aes_bus.ciphertext, CT_B);
      check_bit("stall_in_ready", aes_bus.in_ready, 1'b0);
      check_bit("stall_busy", aes_bus.busy, 1'b1);
      @(posedge clk); #1;
    end
    aes_bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check_bit("post_hs_in_ready", aes_bus.in_ready, 1'b1);
    check_bit("post_hs_out_valid", aes_bus.out_valid, 1'b0);
    check_int("post_hs_pending", exp_q.size(), 0);

    // Reset in the middle of a block, then a clean re-run.
    send(PT_B, rk_b, CT_B, acc);
    repeat (4) @(posedge clk);
    #1;
    void'(exp_q.pop_back());
    apply_reset();
    check_bit("post_reset_out_valid", aes_bus.out_valid, 1'b0);
    send(PT_B, rk_b, CT_B, acc);
    wait_valid(edges);
    check_int("latency_after_reset", edges, 10);
    wait_idle();

    // in_valid pulsed with a different block while busy must be ignored.
    send(PT_B, rk_b, CT_B, acc);
    repeat (3) @(posedge clk);
    #1;
    aes_bus.plaintext = PT_C;
    aes_bus.in_valid  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_bit("pulse_in_ready", aes_bus.in_ready, 1'b0);
    check_bit("pulse_busy", aes_bus.busy, 1'b1);
    aes_bus.in_valid = 1'b0;
    wait_idle();
    repeat (20) @(posedge clk);
    #1;
    check_bit("no_extra_block_busy", aes_bus.busy, 1'b0);
    check_bit("no_extra_block_valid", aes_bus.out_valid, 1'b0);
    check_int("final_pending", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
